mc_request_queue: RTL and testbench
===================================

# mc_request_queue

Timed request queue sitting directly downstream of the trace parser and upstream of the DRAM command scheduler. Accepts parsed trace requests (CPU-cycle timestamp, memory op, 36-bit address) over a valid/ready handshake and buffers them in a 16-entry in-order queue. Releases the head request only once the internal CPU-cycle counter has reached its timestamp. Can optionally fast-forward simulated time when idle.

## Interface
- ADDR_WIDTH, 36, request address width
- MEMOP_WIDTH, 2, op-code width
- TIME_WIDTH, 32, timestamp and cycle-counter width
- DEPTH, 16, queue entries (power of two)
- clk  in  1  single system clock (CPU cycle)
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  parser has a request
- in_ready  out  1  queue can accept; = (count != DEPTH)
- in_time  in  TIME_WIDTH  request issue time, CPU cycles
- in_op  in  MEMOP_WIDTH  0 read, 1 write, 2 ifetch, 3 illegal
- in_addr  in  ADDR_WIDTH  byte address
- skip_en  in  1  enable idle time fast-forward
- out_valid  out  1  head present and head time <= cycle_count
- out_ready  in  1  scheduler takes head
- out_time, out_op, out_addr  out  TIME_WIDTH / MEMOP_WIDTH / ADDR_WIDTH  head entry fields
- cycle_count  out  TIME_WIDTH  current CPU cycle
- count  out  $clog2(DEPTH)+1  occupancy
- order_err  out  1  sticky: accepted time < previous accepted time
- op_err  out  1  sticky: illegal op received

## Operation
- Push: in_valid && in_ready. Legal op → entry written at write pointer, count+1. op==3 → entry dropped, op_err set, handshake still completes.
- Ordering: accepted in_time < last accepted in_time → order_err set, entry still queued (FIFO order kept, no re-sort).
- Pop: out_valid && out_ready → read pointer advances, count-1.
- Simultaneous push and pop: both occur, count unchanged.
- Full: in_ready=0; a pop while full does not raise in_ready until the next cycle (no same-cycle bypass).
- Empty: out_valid=0; out_* fields show stale slot contents, don't care.
- Pointers are log2(DEPTH) bits, wrap naturally; full/empty decided by count only.
- cycle_count: +1 per cycle, saturates at all-ones (no wrap).
- Fast-forward: if skip_en && count==0 && legal push this cycle && in_time > cycle_count+1 → cycle_count <= in_time; otherwise normal increment.
- Last-accepted-time register (for order_err) resets to 0.

## Timing
- Reset (async assert, sync-release behaviour by registers): count=0, pointers=0, cycle_count=0, order_err=0, op_err=0, out_valid=0, in_ready=1. Entries lost on reset mid-operation; no pending handshake survives.
- Push-to-out_valid latency: 1 cycle minimum (registered storage, no fall-through), more if head time > cycle_count.
- out_valid compares head time against registered cycle_count, so an entry with time T is valid no earlier than the cycle in which cycle_count==T.
- out_valid, in_ready and out_* are combinational from registers only; no combinational path from in_* or out_ready to any output.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Package mc_pkg: memop_t enum (MEM_READ=0, MEM_WRITE=1, MEM_IFETCH=2, MEM_ILLEGAL=3), mc_req_t packed struct {time, op, addr}, default width constants shared with parser and scheduler.
- One sub-module: mc_req_fifo (generic sync FIFO of mc_req_t, DEPTH, push/pop/count). Time gating, fast-forward and error flags live in mc_request_queue.

## Test plan
- Reset then push {time=5, op=0, addr=0x1_2345_6780} at cycle 1 → out_valid rises when cycle_count==5, fields match; pop → count 0.
- Push 16 entries time=0 with out_ready=0 → in_ready=0 after 16th, count=16; 17th held off; one pop → in_ready=1 next cycle, not same cycle.
- Simultaneous push/pop at count=8 for 20 cycles → count stays 8, output order equals input order across pointer wrap.
- skip_en=1, empty, push time=1000 at cycle_count=3 → next cycle cycle_count=1000, out_valid=1; with skip_en=0 → out_valid at cycle 1000.
- Push op=3 → op_err=1, count unchanged; push time=50 then time=20 → order_err=1, both popped in push order.
- Assert rst_n low with count=10 mid-pop → all outputs at reset values immediately, queue empty after release.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared request types and default widths for the memory-controller trace path
//
// Purpose : Types and constants shared by the trace parser, the timed request
//           queue and the DRAM command scheduler.
// Contents: MC_* width defaults, memop_t op-code enum, mc_req_t request record,
//           op_is_legal() and time_sat_inc() helpers.

package mc_pkg;

   localparam int MC_ADDR_WIDTH  = 36;
   localparam int MC_MEMOP_WIDTH = 2;
   localparam int MC_TIME_WIDTH  = 32;
   localparam int MC_DEPTH       = 16;

   typedef enum logic [MC_MEMOP_WIDTH-1:0] {
      MEM_READ    = 2'd0,
      MEM_WRITE   = 2'd1,
      MEM_IFETCH  = 2'd2,
      MEM_ILLEGAL = 2'd3
   } memop_t;

   typedef logic [MC_TIME_WIDTH-1:0] mc_time_t;
   typedef logic [MC_ADDR_WIDTH-1:0] mc_addr_t;

   // Field order {time, op, addr}, MSB first.
   typedef struct packed {
      mc_time_t req_time;
      memop_t   op;
      mc_addr_t addr;
   } mc_req_t;

   function automatic logic op_is_legal(input memop_t op);
      return op != MEM_ILLEGAL;
   endfunction

   // Cycle counter step: holds at all-ones instead of wrapping back to zero.
   function automatic mc_time_t time_sat_inc(input mc_time_t t);
      return (&t) ? t : t + mc_time_t'(1);
   endfunction

endpackage

// File: rtl/mc_request_queue_if.sv
// rtl/mc_request_queue_if.sv - request/response bundle between parser, timed queue and scheduler
//
// Purpose : Groups the queue's push side, pop side and status signals.
// Modports: slave  - the queue itself (consumes in_*/out_ready/skip_en,
//                    drives in_ready, out_*, cycle_count, count, error flags)
//           master - the environment (parser + scheduler side)
// Signals : in_valid/in_ready/in_time/in_op/in_addr   push handshake
//           out_valid/out_ready/out_time/out_op/out_addr  pop handshake
//           skip_en        idle fast-forward enable
//           cycle_count    current CPU cycle
//           count          occupancy, $clog2(DEPTH)+1 bits
//           order_err, op_err  sticky error flags

interface mc_request_queue_if
   import mc_pkg::*;
#(
   parameter int DEPTH = MC_DEPTH
);

   logic                          in_valid;
   logic                          in_ready;
   logic [MC_TIME_WIDTH-1:0]      in_time;
   logic [MC_MEMOP_WIDTH-1:0]     in_op;
   logic [MC_ADDR_WIDTH-1:0]      in_addr;
   logic                          skip_en;
   logic                          out_valid;
   logic                          out_ready;
   logic [MC_TIME_WIDTH-1:0]      out_time;
   logic [MC_MEMOP_WIDTH-1:0]     out_op;
   logic [MC_ADDR_WIDTH-1:0]      out_addr;
   logic [MC_TIME_WIDTH-1:0]      cycle_count;
   logic [$clog2(DEPTH):0]        count;
   logic                          order_err;
   logic                          op_err;

   modport slave (
      input  in_valid, in_time, in_op, in_addr, skip_en, out_ready,
      output in_ready, out_valid, out_time, out_op, out_addr,
             cycle_count, count, order_err, op_err
   );

   modport master (
      output in_valid, in_time, in_op, in_addr, skip_en, out_ready,
      input  in_ready, out_valid, out_time, out_op, out_addr,
             cycle_count, count, order_err, op_err
   );

endinterface

// File: rtl/mc_req_fifo.sv
// rtl/mc_req_fifo.sv - synchronous in-order FIFO of mc_req_t records
//
// Purpose : Registered storage for the timed request queue. No fall-through:
//           a pushed entry is visible on rdata_o from the next cycle.
// Ports   : clk_i, rst_ni   clock, asynchronous active-low reset
//           push_i, wdata_i write request and record (ignored when full)
//           pop_i           read-pointer advance (ignored when empty)
//           rdata_o         record at the read pointer (stale when empty)
//           count_o         occupancy
//           empty_o         count_o == 0

module mc_req_fifo
   import mc_pkg::*;
#(
   parameter int DEPTH = MC_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  mc_req_t                wdata_i,
   input  logic                   pop_i,
   output mc_req_t                rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   mc_req_t         mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push;
   logic            do_pop;

   // Full/empty come from the occupancy count alone; pointers just wrap.
   // Fullness is judged on the registered count, so a pop while full never
   // makes room for a push in the same cycle.
   assign do_push = push_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset: slots are only read when count says so.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/mc_request_queue.sv
// rtl/mc_request_queue.sv - timed in-order request queue between trace parser and DRAM scheduler
//
// Purpose : Buffers parsed trace requests and releases the head only once the
//           CPU-cycle counter has reached its timestamp. Optionally jumps the
//           counter forward to the first request's time when the queue is idle.
// Ports   : clk_i    CPU-cycle clock
//           rst_ni   asynchronous active-low reset
//           bus      mc_request_queue_if.slave (push/pop handshakes, skip_en,
//                    cycle_count, count, order_err, op_err)
// All outputs are decoded from registers only; nothing on in_* or out_ready
// reaches an output combinationally.

module mc_request_queue
   import mc_pkg::*;
#(
   parameter int DEPTH = MC_DEPTH
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   mc_request_queue_if.slave   bus
);

   localparam int TW = MC_TIME_WIDTH;
   localparam int CW = $clog2(DEPTH) + 1;

   mc_req_t        push_req;
   mc_req_t        head;
   logic [CW-1:0]  fifo_count;
   logic           fifo_empty;

   logic           push_hs;
   logic           push_legal;
   logic           pop_hs;
   logic           head_due;
   logic           skip_hit;

   mc_time_t       cycle_count_q, cycle_count_d;
   mc_time_t       last_time_q,   last_time_d;
   logic           order_err_q,   order_err_d;
   logic           op_err_q,      op_err_d;

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   assign bus.in_ready = (fifo_count != CW'(DEPTH));
   assign push_hs      = bus.in_valid && bus.in_ready;
   // Illegal ops complete the handshake but are never stored.
   assign push_legal   = push_hs && op_is_legal(memop_t'(bus.in_op));

   assign push_req = '{req_time: bus.in_time,
                       op:       memop_t'(bus.in_op),
                       addr:     bus.in_addr};

   // Gate against the registered counter: time T is due in the cycle where
   // cycle_count == T, never earlier.
   assign head_due      = (head.req_time <= cycle_count_q);
   assign bus.out_valid = !fifo_empty && head_due;
   assign pop_hs        = bus.out_valid && bus.out_ready;

   // Fast-forward only when nothing is waiting and the incoming request lies
   // beyond the next cycle; the extra bit keeps cycle_count+1 from wrapping.
   assign skip_hit = bus.skip_en && (fifo_count == '0) && push_legal &&
                     ({1'b0, bus.in_time} > ({1'b0, cycle_count_q} + (TW+1)'(1)));

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   mc_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_legal),
      .wdata_i (push_req),
      .pop_i   (pop_hs),
      .rdata_o (head),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Cycle counter, last accepted time, sticky error flags
   // ------------------------------------------------------------------
   always_comb begin
      cycle_count_d = skip_hit ? bus.in_time : time_sat_inc(cycle_count_q);
      last_time_d   = last_time_q;
      order_err_d   = order_err_q;
      op_err_d      = op_err_q;

      // Ordering is tracked over stored requests only; a dropped illegal op
      // does not move the reference time.
      if (push_legal) begin
         last_time_d = bus.in_time;
         if (bus.in_time < last_time_q) begin
            order_err_d = 1'b1;
         end
      end

      if (push_hs && !push_legal) begin
         op_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_count_q <= '0;
         last_time_q   <= '0;
         order_err_q   <= 1'b0;
         op_err_q      <= 1'b0;
      end else begin
         cycle_count_q <= cycle_count_d;
         last_time_q   <= last_time_d;
         order_err_q   <= order_err_d;
         op_err_q      <= op_err_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.out_time    = head.req_time;
   assign bus.out_op      = head.op;
   assign bus.out_addr    = head.addr;
   assign bus.cycle_count = cycle_count_q;
   assign bus.count       = fifo_count;
   assign bus.order_err   = order_err_q;
   assign bus.op_err      = op_err_q;

endmodule

// File: tb/tb_mc_request_queue.sv
// tb/tb_mc_request_queue.sv - scoreboard bench for mc_request_queue

module tb_mc_request_queue;
   import mc_pkg::*;

   logic    clk   = 1'b0;
   logic    rst_n = 1'b0;
   int      checks = 0;
   int      errors = 0;
   mc_req_t exp_q[$];
   mc_req_t mon_exp;
   int      n;

   mc_request_queue_if #(.DEPTH(16)) bus ();

   mc_request_queue #(.DEPTH(16)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT completes a pop handshake.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got addr 0x%0h, required no output", bus.out_addr);
         end else begin
            mon_exp = exp_q.pop_front();
            check("out_time", 64'(bus.out_time), 64'(mon_exp.req_time));
            check("out_op",   64'(bus.out_op),   64'(mon_exp.op));
            check("out_addr", 64'(bus.out_addr), 64'(mon_exp.addr));
            check("out_due",  64'(bus.out_time <= bus.cycle_count), 64'd1);
         end
      end
   end

   task automatic step(input int cnt);
      repeat (cnt) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [31:0] t, input logic [1:0] op, input logic [35:0] addr);
      int k = 0;
      bus.in_valid = 1'b1;
      bus.in_time  = t;
      bus.in_op    = op;
      bus.in_addr  = addr;
      @(negedge clk);
      while (!bus.in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("push_accept", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      if (op != 2'd3) exp_q.push_back('{req_time: t, op: memop_t'(op), addr: addr});
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int k = 0;
      bus.out_ready = 1'b1;
      while (bus.count != 0 && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("drain_count", 64'(bus.count), 64'd0);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      bus.out_ready = 1'b0;
   endtask

   task automatic wait_cc(input logic [31:0] target);
      int k = 0;
      while (bus.cycle_count != target && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("wait_cc", 64'(bus.cycle_count), 64'(target));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"},     64'(bus.count),       64'd0);
      check({tag, "_in_ready"},  64'(bus.in_ready),    64'd1);
      check({tag, "_out_valid"}, 64'(bus.out_valid),   64'd0);
      check({tag, "_cc"},        64'(bus.cycle_count), 64'd0);
      check({tag, "_order_err"}, 64'(bus.order_err),   64'd0);
      check({tag, "_op_err"},    64'(bus.op_err),      64'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_time   = '0;
      bus.in_op     = '0;
      bus.in_addr   = '0;
      bus.skip_en   = 1'b0;
      bus.out_ready = 1'b0;

      step(2);
      check_reset_state("reset");
      rst_n = 1'b1;

      // Single timed request: pushed at cycle 1, due at cycle 5.
      bus.out_ready = 1'b1;
      step(1);
      check("t1_cc_start", 64'(bus.cycle_count), 64'd1);
      push(32'd5, 2'd0, 36'h1_2345_6780);
      check("t1_cc_after_push", 64'(bus.cycle_count), 64'd2);
      check("t1_not_due", 64'(bus.out_valid), 64'd0);
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t1_valid", 64'(bus.out_valid), 64'd1);
      check("t1_valid_cc", 64'(bus.cycle_count), 64'd5);
      @(posedge clk);
      #1;
      check("t1_count", 64'(bus.count), 64'd0);
      bus.out_ready = 1'b0;

      // Illegal op and out-of-order timestamps.
      do_reset();
      push(32'd0, 2'd3, 36'h0_dead_beef);
      check("t5_op_err", 64'(bus.op_err), 64'd1);
      check("t5_op_count", 64'(bus.count), 64'd0);
      check("t5_order_clean", 64'(bus.order_err), 64'd0);
      push(32'd50, 2'd1, 36'h0_0000_1000);
      check("t5_order_after50", 64'(bus.order_err), 64'd0);
      check("t5_count1", 64'(bus.count), 64'd1);
      push(32'd20, 2'd2, 36'h0_0000_2000);
      check("t5_order_after20", 64'(bus.order_err), 64'd1);
      check("t5_count2", 64'(bus.count), 64'd2);
      drain(200);

      // Fill to 16, hold off the 17th, single pop frees space only next cycle.
      for (int i = 0; i < 16; i++) push(32'd0, 2'(i % 3), 36'h1000 + 36'(i));
      check("t2_full_count", 64'(bus.count), 64'd16);
      check("t2_full_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b1;
      bus.in_time  = 32'd0;
      bus.in_op    = 2'd1;
      bus.in_addr  = 36'h0_0000_aaaa;
      step(3);
      check("t2_held_count", 64'(bus.count), 64'd16);
      check("t2_held_ready", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t2_no_bypass", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("t2_after_pop_count", 64'(bus.count), 64'd15);
      check("t2_after_pop_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      exp_q.push_back('{req_time: 32'd0, op: MEM_WRITE, addr: 36'h0_0000_aaaa});
      #1;
      bus.in_valid = 1'b0;
      check("t2_refill_count", 64'(bus.count), 64'd16);
      drain(100);

      // Sustained push+pop at occupancy 8 across pointer wrap.
      for (int i = 0; i < 8; i++) push(32'd0, 2'd0, 36'h2000 + 36'(i));
      check("t3_count_start", 64'(bus.count), 64'd8);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'b1;
         bus.in_time  = 32'd0;
         bus.in_op    = 2'(i % 3);
         bus.in_addr  = 36'h3000 + 36'(i);
         @(posedge clk);
         exp_q.push_back('{req_time: 32'd0, op: memop_t'(2'(i % 3)), addr: 36'h3000 + 36'(i)});
         #1;
         check("t3_count", 64'(bus.count), 64'd8);
      end
      bus.in_valid = 1'b0;
      drain(50);
      check("sticky_op_err", 64'(bus.op_err), 64'd1);
      check("sticky_order_err", 64'(bus.order_err), 64'd1);

      // Reset asserted mid-pop with 10 entries.
      for (int i = 0; i < 10; i++) push(32'd0, 2'd0, 36'h4000 + 36'(i));
      check("t6_count", 64'(bus.count), 64'd10);
      bus.out_ready = 1'b1;
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_state("t6_async");
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(2);
      check("t6_post_count", 64'(bus.count), 64'd0);
      check("t6_post_valid", 64'(bus.out_valid), 64'd0);

      // Fast-forward from cycle 3 to 1000.
      do_reset();
      wait_cc(32'd3);
      bus.skip_en = 1'b1;
      push(32'd1000, 2'd0, 36'h0_0000_5000);
      bus.skip_en = 1'b0;
      check("t4_skip_cc", 64'(bus.cycle_count), 64'd1000);
      check("t4_skip_valid", 64'(bus.out_valid), 64'd1);
      drain(5);

      // Same request without fast-forward becomes due at cycle 1000.
      do_reset();
      wait_cc(32'd3);
      push(32'd1000, 2'd0, 36'h0_0000_6000);
      check("t4_noskip_cc", 64'(bus.cycle_count), 64'd4);
      check("t4_noskip_idle", 64'(bus.out_valid), 64'd0);
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 1100) begin
         @(negedge clk);
         n++;
      end
      check("t4_noskip_valid", 64'(bus.out_valid), 64'd1);
      check("t4_noskip_valid_cc", 64'(bus.cycle_count), 64'd1000);
      @(posedge clk);
      #1;
      drain(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
